// File: rtl/msrv32_pkg.sv
// Shared definitions for the machine-mode trap sequencer:
//   - trap FSM state encoding
//   - PC source select codes
//   - SYSTEM opcode and MRET funct7
//   - mcause codes
//   - the packed trap-info record produced by the priority encoder
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } trap_state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;

    // Exception causes (i_or_e = 0)
    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

    // Interrupt causes (i_or_e = 1)
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    typedef struct packed {
        logic       i_or_e;
        logic [3:0] cause;
        logic       misaligned;
    } trap_info_t;

endpackage

// File: rtl/msrv32_trap_prio.sv
// Combinational trap-cause priority encoder.
// Ports:
//   i_irq_mei/msi/mti    in  enabled-and-pending interrupts (already gated by MIE)
//   i_instr_misaligned   in  fetch target misaligned
//   i_illegal            in  illegal instruction
//   i_ebreak / i_ecall   in  decoded system instructions
//   i_load_misaligned    in  load address misaligned
//   i_store_misaligned   in  store address misaligned
//   o_info               out {i_or_e, cause, misaligned}; all zero when nothing is pending
module msrv32_trap_prio
    import msrv32_pkg::*;
(
    input  logic       i_irq_mei,
    input  logic       i_irq_msi,
    input  logic       i_irq_mti,
    input  logic       i_instr_misaligned,
    input  logic       i_illegal,
    input  logic       i_ebreak,
    input  logic       i_ecall,
    input  logic       i_load_misaligned,
    input  logic       i_store_misaligned,
    output trap_info_t o_info
);

    // Fixed priority: any interrupt beats any exception.
    always_comb begin
        o_info.i_or_e     = 1'b0;
        o_info.cause      = 4'd0;
        o_info.misaligned = 1'b0;
        if (i_irq_mei) begin
            o_info.i_or_e = 1'b1;
            o_info.cause  = CAUSE_MEI;
        end else if (i_irq_msi) begin
            o_info.i_or_e = 1'b1;
            o_info.cause  = CAUSE_MSI;
        end else if (i_irq_mti) begin
            o_info.i_or_e = 1'b1;
            o_info.cause  = CAUSE_MTI;
        end else if (i_instr_misaligned) begin
            o_info.cause      = CAUSE_INSTR_MISALIGNED;
            o_info.misaligned = 1'b1;
        end else if (i_illegal) begin
            o_info.cause = CAUSE_ILLEGAL_INSTR;
        end else if (i_ebreak) begin
            o_info.cause = CAUSE_BREAKPOINT;
        end else if (i_ecall) begin
            o_info.cause = CAUSE_ECALL_M;
        end else if (i_load_misaligned) begin
            o_info.cause      = CAUSE_LOAD_MISALIGNED;
            o_info.misaligned = 1'b1;
        end else if (i_store_misaligned) begin
            o_info.cause      = CAUSE_STORE_MISALIGNED;
            o_info.misaligned = 1'b1;
        end else begin
            o_info.cause = 4'd0;
        end
    end

endmodule

// File: rtl/msrv32_trap_control.sv
// Machine-mode trap sequencer. Decides traps on the decoded instruction,
// runs the 4-state trap FSM and drives PC select, flush and CSR trap controls.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in  clock, async active-high reset
//   illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in
//                                                exception flags
//   opcode_6_to_2_in, funct3_in, funct7_in, rs1/rs2/rd_addr_in
//                                                instruction fields (ecall/ebreak/mret decode)
//   mie_in, meie/mtie/msie_in, meip/mtip/msip_in interrupt enable / pending
//   trap_taken_out        trap decided this cycle (combinational)
//   pc_src_out            00 boot, 01 epc, 10 trap vector, 11 next pc
//   flush_out             kill instruction in pipeline register
//   set_cause_out, cause_out, i_or_e_out         mcause write strobe and value
//   set_epc_out           mepc write strobe
//   mie_clear_out / mie_set_out                  mstatus.MIE save / restore
//   instret_inc_out       minstret increment
//   misaligned_exception_out                     mtval = faulting address
module msrv32_trap_control
    import msrv32_pkg::*;
(
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       trap_taken_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out
);

    trap_state_t r_state;
    trap_state_t w_next_state;

    logic       w_is_system;
    logic       w_zero_fields;
    logic       w_ecall;
    logic       w_ebreak;
    logic       w_mret;
    logic       w_exception;
    logic       w_irq_mei;
    logic       w_irq_msi;
    logic       w_irq_mti;
    logic       w_interrupt;
    logic       w_operating;
    trap_info_t w_info;

    logic [3:0] r_cause;
    logic       r_i_or_e;
    logic       r_misaligned;

    assign w_is_system   = (opcode_6_to_2_in == OPCODE_SYSTEM);
    assign w_zero_fields = (funct3_in == 3'd0) && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall       = w_is_system && w_zero_fields && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    assign w_ebreak      = w_is_system && w_zero_fields && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    assign w_mret        = w_is_system && w_zero_fields && (funct7_in == FUNCT7_MRET)
                           && (rs2_addr_in == 5'd2);

    assign w_exception = illegal_instr_in | misaligned_instr_in | misaligned_load_in
                       | misaligned_store_in | w_ecall | w_ebreak;

    // Global MIE gates every interrupt source before prioritisation.
    assign w_irq_mei   = mie_in & meie_in & meip_in;
    assign w_irq_msi   = mie_in & msie_in & msip_in;
    assign w_irq_mti   = mie_in & mtie_in & mtip_in;
    assign w_interrupt = w_irq_mei | w_irq_msi | w_irq_mti;

    assign w_operating     = (r_state == ST_OPERATING);
    assign trap_taken_out  = w_operating & (w_exception | w_interrupt);
    // An mret retires; a trapped instruction does not.
    assign instret_inc_out = w_operating & ~trap_taken_out;

    msrv32_trap_prio u_prio (
        .i_irq_mei          (w_irq_mei),
        .i_irq_msi          (w_irq_msi),
        .i_irq_mti          (w_irq_mti),
        .i_instr_misaligned (misaligned_instr_in),
        .i_illegal          (illegal_instr_in),
        .i_ebreak           (w_ebreak),
        .i_ecall            (w_ecall),
        .i_load_misaligned  (misaligned_load_in),
        .i_store_misaligned (misaligned_store_in),
        .o_info             (w_info)
    );

    // Trap FSM state register.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a pending exception always overrides mret.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET:       w_next_state = ST_OPERATING;
            ST_OPERATING: begin
                if (trap_taken_out) begin
                    w_next_state = ST_TRAP_TAKEN;
                end else if (w_mret) begin
                    w_next_state = ST_TRAP_RETURN;
                end else begin
                    w_next_state = ST_OPERATING;
                end
            end
            ST_TRAP_TAKEN:  w_next_state = ST_OPERATING;
            ST_TRAP_RETURN: w_next_state = ST_OPERATING;
            default:        w_next_state = ST_RESET;
        endcase
    end

    // Latch cause information on entry to TRAP_TAKEN; held until the next trap.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_cause      <= 4'd0;
            r_i_or_e     <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (trap_taken_out) begin
            r_cause      <= w_info.cause;
            r_i_or_e     <= w_info.i_or_e;
            r_misaligned <= w_info.misaligned;
        end else begin
            r_cause      <= r_cause;
            r_i_or_e     <= r_i_or_e;
            r_misaligned <= r_misaligned;
        end
    end

    assign cause_out                = r_cause;
    assign i_or_e_out               = r_i_or_e;
    assign misaligned_exception_out = r_misaligned;

    // Moore outputs decoded from the state register.
    always_comb begin
        pc_src_out    = PC_BOOT;
        flush_out     = 1'b1;
        set_cause_out = 1'b0;
        set_epc_out   = 1'b0;
        mie_clear_out = 1'b0;
        mie_set_out   = 1'b0;
        case (r_state)
            ST_RESET: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
            ST_OPERATING: begin
                pc_src_out = PC_NEXT;
                flush_out  = 1'b0;
            end
            ST_TRAP_TAKEN: begin
                pc_src_out    = PC_TRAP;
                flush_out     = 1'b1;
                set_cause_out = 1'b1;
                set_epc_out   = 1'b1;
                mie_clear_out = 1'b1;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                flush_out   = 1'b1;
                mie_set_out = 1'b1;
            end
            default: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
        endcase
    end

endmodule
